// File: rtl/mem_responder.sv
// Single-port 16-bit memory responder for the Rd/Wr/Stall/Done protocol.
// It models last-line hit/miss latency and zero-fills its memory after every reset.
module mem_responder #(
  parameter int unsigned AW       = 8,
  parameter int unsigned MISS_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  localparam int unsigned TW    = 13;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [15:0]     data_q, data_d;
  logic            rd_q, rd_d;
  logic            hit_q, hit_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic            valid_q, valid_d;

  logic [15:0]     dout_q, dout_d;
  logic            done_q, done_d;
  logic            stall_q, stall_d;
  logic            chit_q, chit_d;
  logic            err_q, err_d;

  logic [15:0]     mem_q [DEPTH];

  logic            accepting, req_legal, req_illegal, accept, hit_now, fwd;
  logic [AW-1:0]   rd_idx;
  logic [15:0]     rdata;

  assign accepting   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign req_legal   = (Rd ^ Wr) && !Addr[0];
  assign req_illegal = (Rd | Wr) && !req_legal;
  assign accept      = accepting && req_legal;
  assign hit_now     = valid_q && (Addr[15:3] == tag_q);

  // Read data for the cycle entering DONE; forwards a write committing on the same edge.
  assign rd_idx = (state_q == S_BUSY) ? idx_q : Addr[AW:1];
  assign fwd    = (state_q == S_DONE) && !rd_q && (idx_q == rd_idx);
  assign rdata  = fwd ? data_q : mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_INIT;
      ptr_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      rd_q     <= 1'b0;
      hit_q    <= 1'b0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      stall_q  <= 1'b1;
      chit_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      hit_q    <= hit_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
      chit_q   <= chit_d;
      err_q    <= err_d;
    end
  end

  // Reset aborts a pending write by gating the DONE commit with rst.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[ptr_q] <= '0;
    end else if (rst && (state_q == S_DONE) && !rd_q) begin
      mem_q[idx_q] <= data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rd_d    = rd_q;
    hit_d   = hit_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = Addr[AW:1];
          data_d  = DataIn;
          rd_d    = Rd;
          hit_d   = hit_now;
          tag_d   = Addr[15:3];
          valid_d = 1'b1;
          if (hit_now) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CW'(MISS_LAT - 2);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    done_d  = (state_d == S_DONE);
    stall_d = (state_d == S_INIT) || (state_d == S_BUSY);
    chit_d  = done_d && hit_d;
    dout_d  = (done_d && rd_d) ? rdata : 16'h0000;
    err_d   = accepting && req_illegal;
  end

  assign DataOut  = dout_q;
  assign Done     = done_q;
  assign Stall    = stall_q;
  assign CacheHit = chit_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers queue expected responses, a monitor
// checks every Done/err pulse against them.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  mem_responder #(.AW(8), .MISS_LAT(4)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
  );

  typedef struct {
    logic        chk;
    logic [15:0] d;
    logic        hit;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pops one expectation, every err pops one expected err cycle.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got Done=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("cachehit", 32'(CacheHit), 32'(mon_e.hit));
        if (mon_e.chk) check("dataout", 32'(DataOut), 32'(mon_e.d));
      end
    end else begin
      check("idle_dataout", 32'(DataOut), 32'h0);
      check("idle_cachehit", 32'(CacheHit), 32'h0);
    end
    if (err === 1'b1) begin
      if (errq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_err: got err=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("err_cycle", cyc, errq.pop_front());
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Done !== 1'b1 && n < 40);
    if (Done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no Done expected one within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  // Drive a request at a negedge, queue its expectation, hold it until Done.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic chk, input logic [15:0] ed, input logic eh, input int lat);
    exp_t e;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    e.chk = chk; e.d = ed; e.hit = eh; e.cyc = cyc + lat;
    sb.push_back(e);
    wait_done();
  endtask

  task automatic rd_req(input logic [15:0] a, input logic [15:0] ed, input logic eh, input int lat);
    issue(1'b1, 1'b0, a, 16'h0, 1'b1, ed, eh, lat);
  endtask

  task automatic wr_req(input logic [15:0] a, input logic [15:0] d, input logic eh, input int lat);
    issue(1'b0, 1'b1, a, d, 1'b0, 16'h0, eh, lat);
  endtask

  task automatic idle();
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic illegal(input logic rd, input logic wr, input logic [15:0] a);
    Rd = rd; Wr = wr; Addr = a; DataIn = 16'h0;
    errq.push_back(cyc + 1);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check("illegal_stall", 32'(Stall), 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (Stall === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected one by 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(Stall), 32'h1);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_cachehit", 32'(CacheHit), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dataout", 32'(DataOut), 32'h0);
    rst = 1'b1;
    wait_init(n);
    check("init_stall_cycles", n, 256);

    // Reset/init, miss then hit, tag change, aliasing
    rd_req(16'h6000, 16'h0000, 1'b0, 4);
    rd_req(16'h7000, 16'h0000, 1'b0, 4);
    wr_req(16'h6004, 16'hBEEF, 1'b0, 4);
    rd_req(16'h6006, 16'h0000, 1'b1, 1);
    rd_req(16'h6004, 16'hBEEF, 1'b1, 1);
    rd_req(16'h6004, 16'hBEEF, 1'b1, 1);
    rd_req(16'h6014, 16'h0000, 1'b0, 4);
    rd_req(16'h6004, 16'hBEEF, 1'b0, 4);
    wr_req(16'h0202, 16'h1234, 1'b0, 4);
    rd_req(16'h8202, 16'h1234, 1'b0, 4);
    idle();
    @(negedge clk);

    // Illegal requests leave data and tag untouched
    illegal(1'b1, 1'b1, 16'h6000);
    illegal(1'b1, 1'b0, 16'h6001);
    rd_req(16'h6000, 16'h0000, 1'b0, 4);

    // 20 back-to-back requests; each read follows its write in the write's Done cycle
    for (int i = 0; i < 10; i++) begin
      wr_req(16'h6100 + 16'(2 * i), 16'hA000 + 16'(i), (i % 4) != 0, ((i % 4) == 0) ? 4 : 1);
      rd_req(16'h6100 + 16'(2 * i), 16'hA000 + 16'(i), 1'b1, 1);
    end
    idle();
    repeat (3) @(negedge clk);

    // Write miss aborted by reset in its second BUSY cycle
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h6200; DataIn = 16'h5555;
    repeat (2) @(negedge clk);
    check("busy_stall", 32'(Stall), 32'h1);
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("abort_stall", 32'(Stall), 32'h1);
    rst = 1'b1;
    wait_init(n);
    check("reinit_stall_cycles", n, 256);
    rd_req(16'h6200, 16'h0000, 1'b0, 4);
    idle();
    repeat (5) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    check("err_queue_drained", errq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable single-port memory responder for the Rd/Wr/Stall/Done request protocol used by the processor's memory-system benches and fetch/data paths. It sits at the far end of a requester: it accepts one 16-bit word request at a time, models a last-line hit/miss latency, and returns Done, DataOut and CacheHit. Its purpose is to stand in for the memory system when testing request generators, and to give benches a deterministic, cycle-exact reference.

## Interface
- AW, 8: word-address width; memory holds 2^AW 16-bit words, indexed by Addr[AW:1].
- MISS_LAT, 4: cycles from acceptance to Done on a miss; legal range 2..15.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- Addr  in  16  byte address; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataOut  out  16  read data; valid only while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  block cannot accept a request this cycle.
- CacheHit  out  1  qualifies Done; the request hit the last-accessed line.
- err  out  1  one-cycle pulse for an illegal request.

## Operation
- States: INIT, IDLE, BUSY, DONE.
- INIT: entered when rst=0 at a posedge. Sweeps a pointer 0..2^AW-1 and writes 0 to one word per cycle. After the last word, goes to IDLE. Requests are ignored during INIT.
- Accepting states are IDLE and DONE. A request is sampled at the posedge ending the cycle.
- Legal request: exactly one of Rd or Wr is set, and Addr[0]=0.
  - On acceptance, latch Addr, DataIn and Rd/Wr.
  - Hit if line_valid=1 and Addr[15:3] equals line_tag.
  - Then update line_tag to Addr[15:3] and set line_valid=1.
- Hit goes directly to DONE. Miss goes to BUSY with the counter loaded to MISS_LAT-2. BUSY decrements the counter and goes to DONE when the counter reaches 0.
- Illegal request (Rd=Wr=1, or Addr[0]=1 with Rd or Wr set): err=1 for the next cycle. The request is dropped: no Done, no memory write, tag unchanged. The state goes to or stays in IDLE.
- DONE: Done=1 and CacheHit=the latched hit flag.
  - Latched write: memory[Addr[AW:1]] gets DataIn on the posedge ending DONE.
  - Latched read: DataOut=memory[Addr[AW:1]].
  - A new request may be accepted in the same cycle. With no request, next state is IDLE.
- Addr bits above AW alias (wrap) in memory. The tag still uses the full Addr[15:3].
- A request must be held stable by the requester until Done, and dropped in the Done cycle. Inputs changing during BUSY are ignored.

## Timing
- Reset (rst=0 at posedge): next cycle has state INIT with pointer 0, Stall=1, Done=0, CacheHit=0, err=0, DataOut=0, line_valid=0.
- INIT lasts 2^AW cycles after rst returns to 1; Stall=1 throughout. With AW=8, Stall falls on cycle 257 after rst rises.
- Stall=1 in INIT and BUSY; Stall=0 in IDLE and DONE.
- Hit latency: request accepted at the end of cycle N; Done=1 in cycle N+1. Stall never rises.
- Miss latency: request accepted at the end of cycle N; Stall=1 in cycles N+1..N+MISS_LAT-1; Done=1 in cycle N+MISS_LAT.
- Back-to-back: a request presented in a Done cycle is accepted at that cycle's end.
- A read following a write to the same word, accepted in the write's Done cycle, returns the new data.
- DataOut, CacheHit and err are 0 whenever Done=0, except err as specified. All outputs are registered.
- rst=0 during BUSY or DONE aborts the request: no Done, no pending write, and the block restarts INIT.

## Test plan
- Reset and init: hold rst=0 for 2 cycles, then release. Stall=1 for exactly 256 cycles (AW=8). A read of 0x6000 then returns 0x0000 with CacheHit=0, Done 4 cycles after acceptance.
- Miss then hit: Wr 0x6004 with data 0xBEEF → Done at +4, CacheHit=0. Rd 0x6006 → Done at +1, CacheHit=1, DataOut=0x0000. Rd 0x6004 → +1, CacheHit=1, DataOut=0xBEEF.
- Tag change: Rd 0x6004, then Rd 0x6014 → second read misses (+4), CacheHit=0. Rd 0x6004 again → miss.
- Aliasing: Wr 0x0202 with 0x1234, then Rd 0x8202 → DataOut=0x1234, CacheHit=0.
- Illegal requests: Rd=Wr=1 at 0x6000, and separately Rd at 0x6001 → err=1 for one cycle, no Done, Stall=0. A following Rd 0x6000 returns prior data.
- Back-to-back and reset mid-flight: 20 requests, each issued in the prior Done cycle, all complete with correct data and none dropped. A Wr miss interrupted by rst=0 at BUSY cycle 2 → no Done, and a later read of that address returns 0x0000.
